// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp sequencer: default field widths,
// the control register address, FSM encoding and the wdata packing helper.
package pwm_pkg;

    localparam int PWM_PERIOD_W   = 16;
    localparam int PWM_DUTY_W     = 16;
    localparam int PWM_DATA_W     = PWM_PERIOD_W + PWM_DUTY_W;
    localparam int PWM_ADDR_W     = 8;
    localparam int PWM_INTERVAL_W = 16;

    localparam logic [PWM_ADDR_W-1:0] PWM_CTRL_ADDR_DFLT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } ramp_state_e;

    // The control register holds period in the upper half, duty in the lower half.
    function automatic logic [PWM_DATA_W-1:0] pack_ctrl(
        input logic [PWM_PERIOD_W-1:0] period,
        input logic [PWM_DUTY_W-1:0]   duty
    );
        return {period, duty};
    endfunction

endpackage

// File: rtl/pwm_interval_timer.sv
// Load/decrement interval counter; expired flags the last cycle of an interval.
// Generic enough to pace any PWM sequencer that spaces bus writes.
module pwm_interval_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-change sequencer: ramps the PWM duty from the last applied
// value to a commanded target through a series of spaced control-register writes.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = PWM_ADDR_W,
    parameter int                    DATA_WIDTH     = PWM_DATA_W,
    parameter int                    WIDTH_PERIOD   = PWM_PERIOD_W,
    parameter int                    WIDTH_DUTY     = PWM_DUTY_W,
    parameter logic [ADDR_WIDTH-1:0] PWM_CTRL_ADDR  = PWM_CTRL_ADDR_DFLT,
    parameter int                    WIDTH_INTERVAL = PWM_INTERVAL_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [WIDTH_PERIOD-1:0]   cfg_period,
    input  logic [WIDTH_DUTY-1:0]     cfg_target,
    input  logic [WIDTH_DUTY-1:0]     cfg_step,
    input  logic [WIDTH_INTERVAL-1:0] cfg_interval,
    input  logic                      abort,
    output logic [ADDR_WIDTH-1:0]     pwm_addr,
    output logic [DATA_WIDTH-1:0]     pwm_wdata,
    output logic                      pwm_wen,
    output logic                      pwm_ren,
    output logic                      busy,
    output logic                      done,
    output logic                      err_cfg,
    output logic [WIDTH_DUTY-1:0]     cur_duty
);

    ramp_state_e               state;
    logic [WIDTH_PERIOD-1:0]   period_q;
    logic [WIDTH_DUTY-1:0]     target_q;
    logic [WIDTH_DUTY-1:0]     step_q;
    logic [WIDTH_INTERVAL-1:0] interval_q;

    logic                      cmd_bad;
    logic [WIDTH_DUTY-1:0]     start_duty;
    logic [WIDTH_DUTY-1:0]     step_sel;
    logic [WIDTH_DUTY-1:0]     target_sel;
    logic [WIDTH_DUTY-1:0]     calc_duty;
    logic [WIDTH_DUTY-1:0]     wr_duty;
    logic [WIDTH_INTERVAL-1:0] interval_eff;
    logic                      timer_expired;

    // One ramp step with a guard bit so start+step cannot wrap past the target.
    function automatic logic [WIDTH_DUTY-1:0] next_duty(
        input logic [WIDTH_DUTY-1:0] start,
        input logic [WIDTH_DUTY-1:0] target,
        input logic [WIDTH_DUTY-1:0] step
    );
        logic [WIDTH_DUTY:0] sum;
        logic [WIDTH_DUTY:0] diff;
        sum  = {1'b0, start} + {1'b0, step};
        diff = {1'b0, start} - {1'b0, target};
        if (start < target) begin
            return (sum > {1'b0, target}) ? target : sum[WIDTH_DUTY-1:0];
        end else if (start > target) begin
            return (diff <= {1'b0, step}) ? target : start - step;
        end
        return target;
    endfunction

    assign cmd_bad = (cfg_period == '0) || (32'(cfg_target) > 32'(cfg_period)) ||
                     (cfg_step == '0);

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        start_duty = cur_duty;
        target_sel = target_q;
        step_sel   = step_q;
        if (state == IDLE) begin
            target_sel = cfg_target;
            step_sel   = cfg_step;
            if (32'(cur_duty) > 32'(cfg_period)) begin
                start_duty = WIDTH_DUTY'(cfg_period);
            end
        end
    end

    assign calc_duty    = next_duty(start_duty, target_sel, step_sel);
    assign wr_duty      = pwm_wdata[WIDTH_DUTY-1:0];
    assign interval_eff = (interval_q == '0) ? WIDTH_INTERVAL'(1) : interval_q;

    pwm_interval_timer #(
        .WIDTH(WIDTH_INTERVAL)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (state == WRITE),
        .load_value (interval_eff),
        .dec        (state == WAIT),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            period_q   <= '0;
            target_q   <= '0;
            step_q     <= '0;
            interval_q <= '0;
            pwm_wen    <= 1'b0;
            pwm_wdata  <= '0;
            cur_duty   <= '0;
            done       <= 1'b0;
            err_cfg    <= 1'b0;
        end else begin
            pwm_wen <= 1'b0;
            done    <= 1'b0;
            err_cfg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cmd_bad) begin
                            err_cfg <= 1'b1;
                        end else begin
                            period_q   <= cfg_period;
                            target_q   <= cfg_target;
                            step_q     <= cfg_step;
                            interval_q <= cfg_interval;
                            pwm_wen    <= 1'b1;
                            pwm_wdata  <= pack_ctrl(cfg_period, calc_duty);
                            state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    cur_duty <= wr_duty;
                    if (abort) begin
                        state <= IDLE;
                    end else if (wr_duty == target_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (timer_expired) begin
                        pwm_wen   <= 1'b1;
                        pwm_wdata <= pack_ctrl(period_q, calc_duty);
                        state     <= WRITE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign pwm_addr  = PWM_CTRL_ADDR;
    assign pwm_ren   = 1'b0;

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Soft-start/soft-change sequencer for the PWM register interface. It accepts a {period, target duty, step, interval} command and drives the PWM control register (addr/wdata/wen) with a series of duty writes that ramp from the last applied duty to the target. Each write is spaced by a programmable number of clk cycles. It rejects illegal commands (duty > period, zero period, zero step) before any bus write. It sits between the host/config logic and the PWM core, and is the only writer of the PWM control register.

Parameters:
ADDR_WIDTH, 8, PWM bus address width
DATA_WIDTH, 32, PWM bus data width; must equal WIDTH_PERIOD + WIDTH_DUTY
WIDTH_PERIOD, 16, period field width
WIDTH_DUTY, 16, duty/step field width
PWM_CTRL_ADDR, 8'h00, address of the PWM {period, duty} control register
WIDTH_INTERVAL, 16, interval counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  command valid
cfg_ready  out  1  high only in IDLE; a command is accepted when cfg_valid && cfg_ready
cfg_period  in  WIDTH_PERIOD  PWM period
cfg_target  in  WIDTH_DUTY  target duty
cfg_step  in  WIDTH_DUTY  duty increment per write
cfg_interval  in  WIDTH_INTERVAL  clk cycles between writes; 0 is treated as 1
abort  in  1  stop the ramp after the current cycle
pwm_addr  out  ADDR_WIDTH  always PWM_CTRL_ADDR
pwm_wdata  out  DATA_WIDTH  {period[31:16], duty[15:0]}
pwm_wen  out  1  one-cycle write strobe
pwm_ren  out  1  constant 0
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the target is reached
err_cfg  out  1  one-cycle pulse when a command is rejected
cur_duty  out  WIDTH_DUTY  last duty written to the PWM

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE.
  - pwm_wen = 0, pwm_wdata = 0, cur_duty = 0.
  - done = 0, err_cfg = 0, busy = 0, cfg_ready = 1.
- All outputs are registered or Moore-decoded from the state register. There is no combinational path from inputs to outputs except cfg_ready (state-decoded only).
- States:
  - IDLE: cfg_ready = 1. On accept, the command is checked.
    - If cfg_period == 0, cfg_target > cfg_period, or cfg_step == 0: err_cfg pulses in the next cycle, state stays IDLE, and no write occurs.
    - Otherwise the command is latched, the start duty is min(cur_duty, cfg_period), and the next state is WRITE.
  - WRITE: exactly one cycle, with pwm_wen = 1 and pwm_wdata = {period_q, next_duty}.
    - cur_duty <= next_duty at the end of the cycle.
    - If next_duty == target_q, go to DONE; otherwise go to WAIT and load the interval counter with max(interval_q, 1).
  - WAIT: the counter decrements each cycle. When it reaches 1, go to WRITE.
  - DONE: done = 1 for one cycle, then IDLE.
- Latency:
  - Command accepted at edge N → pwm_wen is high in the cycle after edge N.
  - The spacing between consecutive pwm_wen pulses is max(interval, 1) + 1 cycles.
  - done is high in the cycle after the last write.
- next_duty (17-bit internal arithmetic, no wrap):
  - Ramping up: min(start + step, target).
  - Ramping down: if (start − target) ≤ step then target, else start − step.
  - Equal: target. This is a single write, which still applies the new period.
- Write count: ceil(|target − start| / step), minimum 1.
- cfg_valid while busy is ignored. Commands are not queued.
- abort:
  - In WAIT: go to IDLE next cycle. No further write, no done pulse.
  - In WRITE: the current write completes, then IDLE with no done pulse.
  - In DONE or IDLE: no effect.
  - cur_duty keeps the last written value in all abort cases.
- Reset mid-ramp: immediate return to reset values. cur_duty = 0, so the next ramp starts from 0.
- err_cfg and done never assert in the same cycle.

Decomposition:
- Shared package pwm_pkg holds:
  - WIDTH_PERIOD, WIDTH_DUTY and DATA_WIDTH constants.
  - PWM_CTRL_ADDR.
  - The FSM state encoding (IDLE, WRITE, WAIT, DONE).
  - A helper to pack {period, duty} into wdata.
- One sub-module, pwm_interval_timer: a load/decrement counter with an expiry flag, also reusable by future PWM sequencers.

Test Plan:
- Reset asserted mid-WAIT → same-cycle async clear: pwm_wen = 0, busy = 0, cur_duty = 0, cfg_ready = 1.
- Ramp up: cmd {period 1000, target 250, step 100, interval 4} from cur_duty 0 → wdata 0x03E80064, 0x03E800C8, 0x03E800FA.
  - Each is a single-cycle wen, 5 cycles apart.
  - done pulses once, in the cycle after the third write; cur_duty = 250.
- Ramp down: cmd {1000, 50, 100, 0} from cur_duty 250 → writes duty 150 then 50, 2 cycles apart; done pulses once.
- Illegal commands:
  - {period 400, target 700, step 10} → err_cfg pulses 1 cycle, zero wen pulses, cur_duty unchanged (50).
  - Repeat with period 0 and with step 0 → same response.
- Clamp / equal target: cur_duty 900, cmd {500, 500, 50, 3} → start clamped to 500, exactly one write 0x01F401F4, then done.
- Abort and busy handling:
  - Abort asserted during the second WAIT of the ramp 0→250 (step 100) → no third write, no done pulse, cur_duty = 200.
  - cfg_valid pulsed while busy → ignored: no extra writes, and latched parameters are unchanged.
